// File: rtl/vga_rx_capture.sv
// vga_rx_capture: samples an HS/VS/RGB565 stream, locks onto its geometry and
// emits one write strobe with coordinates and colour per active pixel.
module vga_rx_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_START  = 144,
  parameter int V_START  = 35,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_stb,
  input  logic          vga_in_hs,
  input  logic          vga_in_vs,
  input  logic [4:0]    vga_in_r,
  input  logic [5:0]    vga_in_g,
  input  logic [4:0]    vga_in_b,
  output logic          px_valid,
  output logic [9:0]    px_x,
  output logic [9:0]    px_y,
  output logic [15:0]   px_rgb,
  output logic          frame_start,
  output logic          locked,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] v_total
);
  typedef enum logic [1:0] {SEARCH, MEASURE, CONFIRM, LOCKED} state_t;
  localparam logic [CW-1:0] MAX = '1;
  localparam logic [CW-1:0] HB = CW'(H_START);
  localparam logic [CW-1:0] HE = CW'(H_START + H_ACTIVE);
  localparam logic [CW-1:0] VB = CW'(V_START);
  localparam logic [CW-1:0] VE = CW'(V_START + V_ACTIVE);
  state_t state, st_n;
  logic s_stb, s_hs, s_vs, p_hs, p_vs, d_stb;
  logic [15:0] s_rgb, d_rgb;
  logic [CW-1:0] h_cnt, v_cnt, h_ref, v_ref, h_ref_n, v_ref_n;
  logic bad, bad_n, h_seen, seen_n;
  logic hs_edge, vs_edge, h_bad, sat, in_win;
  logic [CW-1:0] h_len, v_len;
  assign hs_edge = s_stb && (s_hs == HS_POL) && (p_hs != HS_POL);
  assign vs_edge = s_stb && (s_vs == VS_POL) && (p_vs != VS_POL);
  assign h_len   = h_cnt + 1'b1;
  assign v_len   = hs_edge ? (v_cnt == MAX ? MAX : v_cnt + 1'b1) : v_cnt;
  assign h_bad   = hs_edge && (h_len != h_ref);
  // h_cnt is about to reach saturation on this strobe: HS has gone missing
  assign sat     = s_stb && !hs_edge && (&h_cnt[CW-1:1]);
  assign in_win  = (h_cnt >= HB) && (h_cnt < HE) && (v_cnt >= VB) && (v_cnt < VE);
  assign locked  = (state == LOCKED);
  always_comb begin
    st_n    = state;
    bad_n   = bad;
    seen_n  = h_seen;
    h_ref_n = h_ref;
    v_ref_n = v_ref;
    if (s_stb) begin
      unique case (state)
        SEARCH: if (vs_edge) begin
          st_n   = MEASURE;
          bad_n  = 1'b0;
          seen_n = 1'b0;
        end
        MEASURE: begin
          if (hs_edge && !h_seen) begin
            h_ref_n = h_len;
            seen_n  = 1'b1;
          end else if (h_bad) bad_n = 1'b1;
          if (vs_edge) begin
            if (!bad_n && seen_n && h_ref_n >= HE && v_len >= VE) begin
              v_ref_n = v_len;
              st_n    = CONFIRM;
            end else begin
              bad_n  = 1'b0;
              seen_n = 1'b0;
            end
          end
        end
        CONFIRM: begin
          if (h_bad) bad_n = 1'b1;
          if (vs_edge) begin
            st_n   = (!bad_n && v_len == v_ref) ? LOCKED : MEASURE;
            bad_n  = 1'b0;
            seen_n = 1'b0;
          end
        end
        LOCKED: if (h_bad || (vs_edge && v_len != v_ref)) begin
          st_n   = MEASURE;
          bad_n  = 1'b0;
          seen_n = 1'b0;
        end
      endcase
      if (sat) st_n = SEARCH;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= SEARCH;
      bad    <= 1'b0;
      h_seen <= 1'b0;
      h_ref  <= '0;
      v_ref  <= '0;
    end else begin
      state  <= st_n;
      bad    <= bad_n;
      h_seen <= seen_n;
      h_ref  <= h_ref_n;
      v_ref  <= v_ref_n;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_stb       <= 1'b0;
      s_hs        <= 1'b0;
      s_vs        <= 1'b0;
      s_rgb       <= '0;
      p_hs        <= 1'b0;
      p_vs        <= 1'b0;
      d_stb       <= 1'b0;
      d_rgb       <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_total     <= '0;
      v_total     <= '0;
      frame_start <= 1'b0;
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_rgb      <= '0;
    end else begin
      s_stb       <= pix_stb;
      s_hs        <= vga_in_hs;
      s_vs        <= vga_in_vs;
      s_rgb       <= {vga_in_r, vga_in_g, vga_in_b};
      d_stb       <= s_stb;
      d_rgb       <= s_rgb;
      frame_start <= vs_edge && state == LOCKED && st_n == LOCKED;
      // counters already hold this pixel's position, and state reflects any drop it caused
      px_valid    <= d_stb && locked && in_win;
      if (d_stb && locked && in_win) begin
        px_x   <= 10'(h_cnt - HB);
        px_y   <= 10'(v_cnt - VB);
        px_rgb <= d_rgb;
      end
      if (s_stb) begin
        p_hs  <= s_hs;
        p_vs  <= s_vs;
        h_cnt <= hs_edge ? '0 : (h_cnt == MAX ? MAX : h_cnt + 1'b1);
        v_cnt <= vs_edge ? '0 : v_len;
        if (hs_edge) h_total <= h_len;
        if (vs_edge) v_total <= v_len;
      end
    end
endmodule

// File: tb/tb_vga_rx_capture.sv
// tb_vga_rx_capture: directed streams on a 16x10 geometry (8x4 active) checking
// lock acquisition, loss, timeout, async reset and pixel output.
module tb_vga_rx_capture;
  localparam int HA = 8, VA = 4, HB = 3, VB = 2, HT = 16, VT = 10;
  logic clk = 0, rst_n = 0, pix_stb = 0, hs = 1, vs = 1;
  logic [15:0] rgb = 0;
  logic px_valid, frame_start, locked, px_valid2, frame_start2, locked2;
  logic [9:0] px_x, px_y, px_x2, px_y2;
  logic [15:0] px_rgb, px_rgb2, h0, h1, h2;
  logic [11:0] h_total, v_total, h_total2, v_total2;
  int errs = 0, nchk = 0, npx = 0, npx2 = 0, nfs = 0;
  logic [9:0] fx, fy, lx, ly;
  always #5 clk = ~clk;
  vga_rx_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_START(HB), .V_START(VB),
                   .HS_POL(1'b0), .VS_POL(1'b0), .CW(12)) dut (
    .clk(clk), .rst_n(rst_n), .pix_stb(pix_stb), .vga_in_hs(hs), .vga_in_vs(vs),
    .vga_in_r(rgb[15:11]), .vga_in_g(rgb[10:5]), .vga_in_b(rgb[4:0]),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
    .frame_start(frame_start), .locked(locked), .h_total(h_total), .v_total(v_total));
  vga_rx_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_START(HB), .V_START(VB),
                   .HS_POL(1'b1), .VS_POL(1'b1), .CW(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .pix_stb(pix_stb), .vga_in_hs(~hs), .vga_in_vs(~vs),
    .vga_in_r(rgb[15:11]), .vga_in_g(rgb[10:5]), .vga_in_b(rgb[4:0]),
    .px_valid(px_valid2), .px_x(px_x2), .px_y(px_y2), .px_rgb(px_rgb2),
    .frame_start(frame_start2), .locked(locked2), .h_total(h_total2), .v_total(v_total2));
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  // rgb encodes {raw line, raw column}, so every strobe can be checked against its coordinates
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    h2 = h1;
    h1 = h0;
    h0 = rgb;
    if (px_valid) begin
      if (npx == 0) begin
        fx = px_x;
        fy = px_y;
      end
      lx = px_x;
      ly = px_y;
      npx++;
      check("pos", px_rgb, {8'(px_y + 10'(VB)), 8'(px_x + 10'(HB))});
      check("lat", px_rgb, h2);
    end
    if (px_valid2) npx2++;
    if (frame_start) nfs++;
  endtask
  task automatic pix(input logic h, input logic v, input logic [15:0] c);
    hs = h;
    vs = v;
    rgb = c;
    pix_stb = 1;
    tick();
    pix_stb = 0;
    tick();
  endtask
  task automatic idle(input int n);
    repeat (n) pix(1'b1, 1'b1, 16'h0);
  endtask
  task automatic frame(input int nl, input int long_line);
    int len;
    for (int l = 0; l < nl; l++) begin
      len = (l == long_line) ? HT + 1 : HT;
      for (int h = 0; h < len; h++)
        pix(h < 2 ? 1'b0 : 1'b1, l == 0 ? 1'b0 : 1'b1, {8'(l), 8'(h)});
    end
  endtask
  initial begin
    repeat (3) tick();
    check("rst_valid", px_valid, 0);
    check("rst_lock", locked, 0);
    check("rst_htot", h_total, 0);
    check("rst_vtot", v_total, 0);
    check("rst_fs", frame_start, 0);
    check("rst_rgb", px_rgb, 0);
    rst_n = 1;
    idle(5);
    frame(VT, -1);
    check("lock_f1", locked, 0);
    frame(VT, -1);
    check("lock_f2", locked, 0);
    npx = 0;
    npx2 = 0;
    frame(VT, -1);
    check("lock_f3", locked, 1);
    check("npx_f3", npx, HA * VA);
    check("first_x", fx, 0);
    check("first_y", fy, 0);
    check("last_x", lx, HA - 1);
    check("last_y", ly, VA - 1);
    check("h_total", h_total, HT);
    check("v_total", v_total, VT);
    check("lock2_f3", locked2, 1);
    check("npx2_f3", npx2, HA * VA);
    check("h_total2", h_total2, HT);
    nfs = 0;
    frame(VT, -1);
    check("fs_count", nfs, 1);
    npx = 0;
    npx2 = 0;
    frame(VT, 3);
    check("long_lock", locked, 0);
    check("long_npx", npx, 2 * HA);
    check("long_npx2", npx2, 2 * HA);
    frame(VT, -1);
    check("long_relock1", locked, 0);
    npx = 0;
    frame(VT, -1);
    check("long_relock2", locked, 1);
    check("long_npx2f", npx, HA * VA);
    idle(HT * 255 - 1);
    check("to_before", locked, 1);
    idle(1);
    check("to_after", locked, 0);
    frame(VT, -1);
    frame(VT, -1);
    check("to_relock2", locked, 0);
    npx = 0;
    frame(VT, -1);
    check("to_relock3", locked, 1);
    check("to_npx", npx, HA * VA);
    frame(4, -1);
    idle(5);
    #2 rst_n = 0;
    #1;
    check("arst_lock", locked, 0);
    check("arst_htot", h_total, 0);
    check("arst_vtot", v_total, 0);
    check("arst_x", px_x, 0);
    check("arst_valid", px_valid, 0);
    tick();
    rst_n = 1;
    idle(5);
    frame(VT, -1);
    frame(VT, -1);
    check("arst_relock2", locked, 0);
    npx = 0;
    frame(VT, -1);
    check("arst_relock3", locked, 1);
    check("arst_npx", npx, HA * VA);
    frame(VT, 3);
    frame(VT - 1, -1);
    frame(VT, -1);
    check("short_lock", locked, 0);
    check("short_vtot", v_total, VT - 1);
    frame(VT, -1);
    check("short_lock2", locked, 0);
    npx = 0;
    frame(VT, -1);
    check("short_relock", locked, 1);
    check("short_npx", npx, HA * VA);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
